// File: rtl/four_way_distributor.sv
// 1-to-4 distributor: one input stream routed by {s1,s0} or a round-robin
// pointer into four single-entry valid/ready output buffers.
module four_way_distributor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             mode,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             o0_valid,
  output logic             o1_valid,
  output logic             o2_valid,
  output logic             o3_valid,
  input  logic             o0_ready,
  input  logic             o1_ready,
  input  logic             o2_ready,
  input  logic             o3_ready,
  output logic [1:0]       rr_ptr,
  output logic [CNT_W-1:0] count
);

  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [3:0]            valid_q, valid_d;
  logic [3:0]            ready;
  logic [1:0]            tgt;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  accept;

  assign ready = {o3_ready, o2_ready, o1_ready, o0_ready};

  // rst_n gates in_ready so nothing is offered as accepted while held in reset
  always_comb begin
    tgt      = mode ? rr_ptr_q : {s1, s0};
    in_ready = rst_n && (!valid_q[tgt] || ready[tgt]);
    accept   = in_valid && in_ready;
  end

  // A load on the target channel takes priority over its drain: no bubble
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (accept && tgt == 2'(k)) begin
        data_d[k]  = in;
        valid_d[k] = 1'b1;
      end else if (ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    rr_ptr_d = (accept && mode) ? rr_ptr_q + 2'd1 : rr_ptr_q;
    count_d  = accept ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      valid_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o0       = data_q[0];
  assign o1       = data_q[1];
  assign o2       = data_q[2];
  assign o3       = data_q[3];
  assign o0_valid = valid_q[0];
  assign o1_valid = valid_q[1];
  assign o2_valid = valid_q[2];
  assign o3_valid = valid_q[3];
  assign rr_ptr   = rr_ptr_q;
  assign count    = count_q;

endmodule

// File: tb/tb_four_way_distributor.sv
// Bench for four_way_distributor: a per-channel buffer model checked every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_four_way_distributor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             in_valid, in_ready, s0, s1, mode;
  logic [WIDTH-1:0] o0, o1, o2, o3;
  logic             o0_valid, o1_valid, o2_valid, o3_valid;
  logic             o0_ready, o1_ready, o2_ready, o3_ready;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  four_way_distributor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1), .mode(mode),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .o0_valid(o0_valid), .o1_valid(o1_valid), .o2_valid(o2_valid), .o3_valid(o3_valid),
    .o0_ready(o0_ready), .o1_ready(o1_ready), .o2_ready(o2_ready), .o3_ready(o3_ready),
    .rr_ptr(rr_ptr), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model: four mailboxes, a pointer mod 4, a counter mod 2^CNT_W
  int mdl_data [4];
  bit mdl_valid [4];
  int mdl_rr;
  int mdl_count;

  function automatic int mdl_target();
    return mode ? mdl_rr : (s1 ? 2 : 0) + (s0 ? 1 : 0);
  endfunction

  function automatic bit cons_ready(int k);
    case (k)
      0: return o0_ready;
      1: return o1_ready;
      2: return o2_ready;
      default: return o3_ready;
    endcase
  endfunction

  function automatic bit mdl_in_ready();
    int t;
    t = mdl_target();
    return rst_n && (!mdl_valid[t] || cons_ready(t));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mdl_data[k]  = 0;
        mdl_valid[k] = 0;
      end
      mdl_rr    = 0;
      mdl_count = 0;
    end else begin
      int t;
      bit acc;
      t   = mdl_target();
      acc = in_valid && mdl_in_ready();
      for (int k = 0; k < 4; k++)
        if (mdl_valid[k] && cons_ready(k)) mdl_valid[k] = 0;
      if (acc) begin
        mdl_data[t]  = int'(in);
        mdl_valid[t] = 1;
        mdl_count    = (mdl_count + 1) % (1 << CNT_W);
        if (mode) mdl_rr = (mdl_rr + 1) % 4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m_in_ready", 32'(in_ready), 32'(mdl_in_ready()));
    chk("m_rr_ptr",   32'(rr_ptr),   32'(mdl_rr));
    chk("m_count",    32'(count),    32'(mdl_count));
    chk("m_o0_valid", 32'(o0_valid), 32'(mdl_valid[0]));
    chk("m_o1_valid", 32'(o1_valid), 32'(mdl_valid[1]));
    chk("m_o2_valid", 32'(o2_valid), 32'(mdl_valid[2]));
    chk("m_o3_valid", 32'(o3_valid), 32'(mdl_valid[3]));
    chk("m_o0", 32'(o0), 32'(mdl_data[0]));
    chk("m_o1", 32'(o1), 32'(mdl_data[1]));
    chk("m_o2", 32'(o2), 32'(mdl_data[2]));
    chk("m_o3", 32'(o3), 32'(mdl_data[3]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {o3_ready, o2_ready, o1_ready, o0_ready} = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sel_data [4];
    sel_data[0] = 8'hA1; sel_data[1] = 8'hB2; sel_data[2] = 8'hC3; sel_data[3] = 8'hD4;

    rst_n = 1'b0; in = '0; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0; mode = 1'b0;
    set_ready(4'b0000);
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 1);

    // Select mode: A1..D4 to channels 0..3, one per cycle, consumers idle
    for (int i = 0; i < 4; i++) begin
      in = sel_data[i]; {s1, s0} = 2'(i); in_valid = 1'b1;
      step();
      chk("sel_valid_rise", 32'({o3_valid, o2_valid, o1_valid, o0_valid}), 32'((1 << (i + 1)) - 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sel_o0", 32'(o0), 32'hA1);
    chk("sel_o1", 32'(o1), 32'hB2);
    chk("sel_o2", 32'(o2), 32'hC3);
    chk("sel_o3", 32'(o3), 32'hD4);
    chk("sel_count", 32'(count), 4);
    chk("sel_rr", 32'(rr_ptr), 0);

    // Backpressure on channel 1
    in = 8'h55; {s1, s0} = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    chk("bp_o1_hold", 32'(o1), 32'hB2);
    chk("bp_count_hold", 32'(count), 4);
    o1_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0; o1_ready = 1'b0;
    chk("bp_o1_valid", 32'(o1_valid), 1);
    chk("bp_o1_new", 32'(o1), 32'h55);
    chk("bp_count", 32'(count), 5);

    // Drain everything; data holds its last value
    set_ready(4'b1111);
    step();
    chk("drain_valids", 32'({o3_valid, o2_valid, o1_valid, o0_valid}), 0);
    chk("drain_o0_hold", 32'(o0), 32'hA1);

    // Round-robin with wrap, full throughput
    mode = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in = 8'(i);
      @(negedge clk);
      chk("rr_ptr_seq", 32'(rr_ptr), 32'((i - 1) % 4));
      chk("rr_in_ready", 32'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rr_ptr_end", 32'(rr_ptr), 2);
    chk("rr_count", 32'(count), 11);
    chk("rr_o0", 32'(o0), 5);
    chk("rr_o1", 32'(o1), 6);
    chk("rr_o2", 32'(o2), 3);
    chk("rr_o3", 32'(o3), 4);
    step();

    // Round-robin blocking on a full channel 2, then bypass via select mode
    mode = 1'b0; {s1, s0} = 2'b10; in = 8'h77; in_valid = 1'b1;
    set_ready(4'b1011);
    step();
    mode = 1'b1; in = 8'h88;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("blk_in_ready", 32'(in_ready), 0);
      chk("blk_rr", 32'(rr_ptr), 2);
      step();
    end
    mode = 1'b0; {s1, s0} = 2'b11;
    @(negedge clk);
    chk("byp_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("byp_o3", 32'(o3), 32'h88);
    chk("byp_o3_valid", 32'(o3_valid), 1);
    chk("byp_o2_held", 32'(o2), 32'h77);
    chk("byp_rr", 32'(rr_ptr), 2);
    chk("byp_count", 32'(count), 13);

    // Reach rr_ptr=3 with o2 full, then reset mid-cycle
    mode = 1'b1; in = 8'h99; in_valid = 1'b1; o2_ready = 1'b1;
    step();
    in_valid = 1'b0; o2_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_o2_valid", 32'(o2_valid), 1);
    chk("pre_rst_rr", 32'(rr_ptr), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valids", 32'({o3_valid, o2_valid, o1_valid, o0_valid}), 0);
    chk("arst_o2", 32'(o2), 0);
    chk("arst_rr", 32'(rr_ptr), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1; mode = 1'b0;
    @(negedge clk);
    chk("arel_in_ready", 32'(in_ready), 1);

    // Counter wrap with CNT_W=4
    {s1, s0} = 2'b00; set_ready(4'b0001); in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in = 8'(i);
      step();
      if (i == 15) chk("cnt_15", 32'(count), 15);
      if (i == 16) chk("cnt_wrap0", 32'(count), 0);
      if (i == 17) chk("cnt_wrap1", 32'(count), 1);
    end
    in_valid = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_way_distributor.md
Name: four_way_distributor

Overview:
- 1-to-4 routing block: the reverse direction of the team's 4-to-1 selector (i0..i3, s1/s0 -> out).
- Accepts a stream of words on one input channel and delivers each word to one of four output channels.
- Target channel comes either from the select pair {s1,s0} or from an internal round-robin pointer.
- Each output channel has a one-entry registered buffer with valid/ready handshake; sits between a single producer and four consumers.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  input data word.
- in_valid  input  1  producer presents a word on `in`.
- in_ready  output  1  block accepts the word this cycle.
- s0  input  1  channel select LSB (mode=0).
- s1  input  1  channel select MSB (mode=0).
- mode  input  1  0 = route by {s1,s0}; 1 = round-robin.
- o0, o1, o2, o3  output  WIDTH each  channel 0..3 data.
- o0_valid..o3_valid  output  1 each  channel k holds a word.
- o0_ready..o3_ready  input  1 each  consumer k takes the word this cycle.
- rr_ptr  output  2  current round-robin pointer.
- count  output  CNT_W  number of accepted input words, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): all ok_valid=0, all ok=0, rr_ptr=0, count=0. Internal state clears immediately, independent of clk. Release is synchronous to the next clk edge. In-flight buffered words are discarded.
- Target channel t (combinational): mode=0 -> t={s1,s0}; mode=1 -> t=rr_ptr.
- in_ready = !ot_valid || ot_ready for channel t. This is combinational from mode/s1/s0/rr_ptr and the ready/valid of channel t. in_ready is low during reset.
- Accept: in_valid && in_ready at a clk edge. ot<=in and ot_valid<=1 on that edge, so latency is 1 cycle from accept to ot_valid.
- Output drain: ok_valid && ok_ready at an edge -> ok_valid<=0, unless the same edge also accepts a new word into channel k.
- Simultaneous drain and accept on the same channel: the buffer loads the new word and ok_valid stays 1. No bubble, giving full throughput of 1 word/cycle per channel.
- ok holds its last value after drain. Data is meaningful only while ok_valid=1.
- Non-target channels are unaffected by the input handshake and drain independently.
- rr_ptr:
  - Increments by 1 on each accept while mode=1, wrapping 3 -> 0.
  - Holds while mode=0 and while mode=1 without accept.
- Mode switch takes effect combinationally for t. rr_ptr is never reset by a mode switch.
- count increments by 1 on every accept in either mode and wraps from 2^CNT_W-1 to 0.
- Producer rule: in and target select must be stable while in_valid=1 && in_ready=0. The block does not check this.
- Stall: if channel t is full and not draining, in_ready=0 and nothing changes (rr_ptr does not advance). In round-robin mode this blocks the input even if other channels are empty; there is no skip-ahead.
- No state machine beyond the four buffer-valid flags, rr_ptr and count.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with o2_valid=1 and rr_ptr=3 -> immediately all valids=0, rr_ptr=0, count=0, in_ready=0; after release in_ready=1.
- Select mode: mode=0, all oN_ready=0, send 0xA1 with {s1,s0}=00, then 0xB2 with 01, 0xC3 with 10, 0xD4 with 11, one per cycle -> each oN_valid rises 1 cycle after its accept with o0..o3=A1,B2,C3,D4; count=4; rr_ptr=0.
- Backpressure: o1 full, o1_ready=0, in_valid=1 with {s1,s0}=01 for 3 cycles -> in_ready=0, o1 keeps its old word, count unchanged. Raise o1_ready -> accept on that edge, o1_valid stays 1 with the new word.
- Round-robin with wrap: mode=1, all oN_ready=1, in_valid=1 for 6 cycles with data 1..6 -> words land on channels 0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2; count=6; full throughput.
- Round-robin blocking: mode=1, rr_ptr=2, o2 full with o2_ready=0, o3 empty -> in_ready=0 and rr_ptr stays 2. Switch mode=0 with {s1,s0}=11 -> in_ready=1, word goes to o3, rr_ptr still 2.
- Counter wrap: CNT_W=4, 17 accepts -> count reads 15 then 0 then 1.
